// File: rtl/enc_16x4_seq_pkg.sv
// Shared definitions for the sequential 16-to-4 encoder.
// Holds the vector/index widths, the FSM state type and a popcount helper
// sized so that a full 16-bit vector (count 16) still fits.
package enc_16x4_seq_pkg;

  localparam int N     = 16;     // request vector width
  localparam int W     = 4;      // encoded index width, log2(N)
  localparam int CNT_W = W + 1;  // popcount width, holds 0..N

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/enc_16x4_seq_if.sv
// Handshake bundle for enc_16x4_seq.
// Input side : in_valid/in_ready with the d_in request vector.
// Output side: out_valid/out_ready with e_out, out_last, remain, plus the
//              zero_in pulse reporting an accepted all-zero vector.
// slave  : the encoder's view.
// master : the surrounding environment's view (producer and consumer).
interface enc_16x4_seq_if;
  import enc_16x4_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     d_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     e_out;
  logic             out_last;
  logic [CNT_W-1:0] remain;
  logic             zero_in;

  modport slave (
    input  in_valid, d_in, out_ready,
    output in_ready, out_valid, e_out, out_last, remain, zero_in
  );

  modport master (
    output in_valid, d_in, out_ready,
    input  in_ready, out_valid, e_out, out_last, remain, zero_in
  );

endinterface

// File: rtl/enc_16x4_seq_lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   vec  in  N  vector to encode
//   idx  out W  index of the lowest set bit (0 when vec is all zero)
//   any  out 1  at least one bit of vec is set
module lsb_prio_enc
  import enc_16x4_seq_pkg::*;
(
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/enc_16x4_seq.sv
// Sequential 16-to-4 encoder: accepts a multi-hot request vector and emits
// the index of every set bit, lowest first, one per output handshake.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of enc_16x4_seq_if (input and output handshakes)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a vector; all-zero vector pulses zero_in
// EMIT  | out_valid=1, presenting lowest pending index until drained
module enc_16x4_seq
  import enc_16x4_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  enc_16x4_seq_if.slave bus
);

  state_t           state, state_n;
  logic [N-1:0]     pending, pending_n;
  logic [N-1:0]     pend_cand;
  logic [W-1:0]     enc_idx;
  logic             enc_any;
  logic [CNT_W-1:0] d_cnt;

  logic             in_ready_n, out_valid_n, out_last_n, zero_in_n;
  logic [W-1:0]     e_out_n;
  logic [CNT_W-1:0] remain_n;

  // The single encoder looks at what pending would become: the incoming
  // vector while idle, or pending minus the index being handed off in EMIT.
  assign pend_cand = (state == IDLE) ? bus.d_in
                                     : (pending & ~(N'(1) << bus.e_out));
  assign d_cnt     = popcount(bus.d_in);

  lsb_prio_enc u_enc (
    .vec (pend_cand),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.e_out     <= '0;
      bus.out_last  <= 1'b0;
      bus.remain    <= '0;
      bus.zero_in   <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      bus.in_ready  <= in_ready_n;
      bus.out_valid <= out_valid_n;
      bus.e_out     <= e_out_n;
      bus.out_last  <= out_last_n;
      bus.remain    <= remain_n;
      bus.zero_in   <= zero_in_n;
    end
  end

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    in_ready_n  = bus.in_ready;
    out_valid_n = bus.out_valid;
    e_out_n     = bus.e_out;
    out_last_n  = bus.out_last;
    remain_n    = bus.remain;
    zero_in_n   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (!enc_any) begin
            zero_in_n = 1'b1;
          end else begin
            state_n     = EMIT;
            pending_n   = pend_cand;
            in_ready_n  = 1'b0;
            out_valid_n = 1'b1;
            e_out_n     = enc_idx;
            remain_n    = d_cnt;
            out_last_n  = (d_cnt == CNT_W'(1));
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pending_n = pend_cand;
          if (enc_any) begin
            e_out_n    = enc_idx;
            remain_n   = bus.remain - CNT_W'(1);
            out_last_n = (bus.remain == CNT_W'(2));
          end else begin
            // Last index taken; e_out keeps its final value.
            state_n     = IDLE;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            remain_n    = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
